// File: rtl/mc_control_fsm_pkg.sv
// ctrl_pkg: shared constants and types for the multi-cycle control unit.
// Holds opcode encodings, the FSM state enum, datapath mux encodings,
// ALU operation codes and exception causes.
package ctrl_pkg;

    localparam logic [5:0] OP_LW   = 6'b000011;
    localparam logic [5:0] OP_SW   = 6'b001011;
    localparam logic [5:0] OP_ADD  = 6'b100010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SUBI = 6'b111000;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_JUMP = 6'b010010;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEM_RD = 4'd4,
        MEM_WR = 4'd5,
        WB_MEM = 4'd6,
        EXEC_R = 4'd7,
        EXEC_I = 4'd8,
        WB_R   = 4'd9,
        WB_I   = 4'd10,
        BRANCH = 4'd11,
        JUMP   = 4'd12,
        EXC    = 4'd13
    } state_e;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_4      = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alusrcb_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_EXC    = 2'b11
    } pc_src_e;

    localparam int ALU_ADD = 2;
    localparam int ALU_SUB = 6;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // States that own a live memory request; stall never freezes these.
    function automatic logic is_mem_state(state_e s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Shared memory-port handshake between the control FSM and memory.
//   mem_req   : request held until mem_ready is seen
//   mem_we    : write enable for the current request
//   iord      : address select, 0=PC, 1=ALUOut
//   mem_ready : memory completes the current request
interface mc_control_fsm_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, mem_we, iord, input mem_ready);
    modport slave  (input mem_req, mem_we, iord, output mem_ready);
endinterface

// File: rtl/mc_control_fsm_mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory request waits without mem_ready.
//   clr     : restart from zero (entry into a waiting state)
//   active  : a request is outstanding this cycle
//   ready   : memory completes this cycle
//   expired : the wait limit is hit this cycle with no completion
// MEM_TIMEOUT=0 disables expiry entirely.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic active,
    input  logic ready,
    output logic expired
);
    localparam int W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LAST = (MEM_TIMEOUT == 0) ? '0 : W'(MEM_TIMEOUT - 1);
    localparam logic ENABLED = (MEM_TIMEOUT != 0);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        cnt <= '0;
        else if (clr)                      cnt <= '0;
        else if (ENABLED && active && !ready) cnt <= cnt + W'(1);
    end

    // A completion in the same cycle as the limit wins.
    assign expired = ENABLED && active && !ready && (cnt == LAST);
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS-style control unit.
// Sequences fetch/decode/execute/memory/writeback over one shared memory
// port, raises illegal-opcode and bus-timeout exceptions, honours a stall
// request outside memory states and counts retired instructions.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mem                 : memory handshake (master side)
//   opcode, funct       : from IR
//   alu_zero, stall     : ALU zero flag, freeze request
//   ir_write .. aluctl  : datapath enables and selects
//   exc_valid/exc_cause : one-cycle exception pulse and its cause
//   retired, state_o    : retired count, current state for debug
module mc_control_fsm
    import ctrl_pkg::*;
#(
    parameter int OPC_W       = 6,
    parameter int FUNCT_W     = 6,
    parameter int ALUCTL_W    = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mc_control_fsm_if.master    mem,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                alu_zero,
    input  logic                stall,
    output logic                ir_write,
    output logic                pc_en,
    output logic                regwrite,
    output logic                regdst,
    output logic                memtoreg,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          pc_src,
    output logic [ALUCTL_W-1:0] aluctl,
    output logic                exc_valid,
    output logic [1:0]          exc_cause,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state_o
);
    state_e     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       hold, expired, timer_clr, retire;
    logic       mem_req_c, mem_we_c, iord_c;
    logic       unused_funct;

    localparam logic [ALUCTL_W-1:0] ALU_ADD_C = ALUCTL_W'(ALU_ADD);
    localparam logic [ALUCTL_W-1:0] ALU_SUB_C = ALUCTL_W'(ALU_SUB);

    // Only the low ALUCTL_W funct bits select the ALU op.
    assign unused_funct = ^funct;

    assign hold = stall && !is_mem_state(state_q);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .active  (is_mem_state(state_q)),
        .ready   (mem.mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
            retired <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH: begin
                if (mem.mem_ready) state_d = DECODE;
                else if (expired) begin
                    state_d = EXC;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                case (opcode)
                    OPC_W'(OP_LW), OPC_W'(OP_SW):     state_d = MEMADR;
                    OPC_W'(OP_ADD):                   state_d = EXEC_R;
                    OPC_W'(OP_ADDI), OPC_W'(OP_SUBI): state_d = EXEC_I;
                    OPC_W'(OP_BEQ), OPC_W'(OP_BNE):   state_d = BRANCH;
                    OPC_W'(OP_JUMP):                  state_d = JUMP;
                    default: begin
                        state_d = EXC;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            MEMADR: state_d = (opcode == OPC_W'(OP_SW)) ? MEM_WR : MEM_RD;
            MEM_RD, MEM_WR: begin
                if (mem.mem_ready) state_d = (state_q == MEM_RD) ? WB_MEM : FETCH;
                else if (expired) begin
                    state_d = EXC;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            EXEC_R: state_d = WB_R;
            EXEC_I: state_d = WB_I;
            WB_MEM, WB_R, WB_I, BRANCH, JUMP, EXC: state_d = FETCH;
            default: state_d = IDLE;
        endcase
        if (hold) begin
            state_d = state_q;
            cause_d = cause_q;
        end
    end

    // Any completed instruction returns to FETCH; exceptions and the
    // power-up path do not count.
    assign retire = (state_d == FETCH) && (state_q != FETCH) &&
                    (state_q != IDLE) && (state_q != EXC);

    assign timer_clr = is_mem_state(state_d) && (state_d != state_q);

    always_comb begin
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        iord_c    = 1'b0;
        ir_write  = 1'b0;
        pc_en     = 1'b0;
        regwrite  = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = SRCB_B;
        pc_src    = PC_ALU;
        aluctl    = '0;
        exc_valid = 1'b0;
        exc_cause = CAUSE_NONE;
        case (state_q)
            FETCH: begin
                mem_req_c = 1'b1;
                alusrcb   = SRCB_4;
                aluctl    = ALU_ADD_C;
                ir_write  = mem.mem_ready;
                pc_en     = mem.mem_ready;
            end
            DECODE: begin
                alusrcb = SRCB_IMM_SH;
                aluctl  = ALU_ADD_C;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluctl  = ALU_ADD_C;
            end
            MEM_RD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
            end
            MEM_WR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                iord_c    = 1'b1;
            end
            WB_MEM: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            EXEC_R, WB_R: begin
                alusrca  = 1'b1;
                aluctl   = funct[ALUCTL_W-1:0];
                regwrite = (state_q == WB_R);
                regdst   = (state_q == WB_R);
            end
            EXEC_I, WB_I: begin
                alusrca  = 1'b1;
                alusrcb  = SRCB_IMM;
                aluctl   = (opcode == OPC_W'(OP_SUBI)) ? ALU_SUB_C : ALU_ADD_C;
                regwrite = (state_q == WB_I);
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluctl  = ALU_SUB_C;
                pc_src  = PC_ALUOUT;
                pc_en   = (opcode == OPC_W'(OP_BNE)) ? !alu_zero : alu_zero;
            end
            JUMP: begin
                pc_src = PC_JUMP;
                pc_en  = 1'b1;
            end
            EXC: begin
                pc_src    = PC_EXC;
                pc_en     = 1'b1;
                exc_valid = 1'b1;
                exc_cause = cause_q;
            end
            default: ;
        endcase
        if (hold) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            regwrite  = 1'b0;
            exc_valid = 1'b0;
        end
    end

    assign mem.mem_req = mem_req_c;
    assign mem.mem_we  = mem_we_c;
    assign mem.iord    = iord_c;
    assign state_o     = state_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm (MEM_TIMEOUT=4, CNT_W=4).
// Each step pushes its expected values to a scoreboard queue, then the
// queue is drained against the settled DUT outputs.
module tb_mc_control_fsm;
    import ctrl_pkg::*;

    typedef enum int {
        K_STATE, K_MEMREQ, K_MEMWE, K_IORD, K_IRW, K_PCEN, K_REGW, K_REGDST,
        K_MEMTOREG, K_ALUSRCA, K_ALUSRCB, K_PCSRC, K_ALUCTL, K_EXCV, K_CAUSE, K_RET
    } kind_e;

    typedef struct {
        string       tag;
        kind_e       kind;
        logic [31:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       alu_zero, stall;
    logic       ir_write, pc_en, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pc_src, exc_cause;
    logic [3:0] aluctl;
    logic       exc_valid;
    logic [3:0] retired;
    logic [3:0] state_o;

    exp_t       sb[$];
    int         compared = 0;
    int         mism = 0;
    int         step = 0;
    logic [3:0] exp_ret;
    logic [5:0] f;

    mc_control_fsm_if mif();

    mc_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem(mif), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .stall(stall), .ir_write(ir_write), .pc_en(pc_en),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .pc_src(pc_src), .aluctl(aluctl),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .retired(retired),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(kind_e k);
        case (k)
            K_STATE:    return 32'(state_o);
            K_MEMREQ:   return 32'(mif.mem_req);
            K_MEMWE:    return 32'(mif.mem_we);
            K_IORD:     return 32'(mif.iord);
            K_IRW:      return 32'(ir_write);
            K_PCEN:     return 32'(pc_en);
            K_REGW:     return 32'(regwrite);
            K_REGDST:   return 32'(regdst);
            K_MEMTOREG: return 32'(memtoreg);
            K_ALUSRCA:  return 32'(alusrca);
            K_ALUSRCB:  return 32'(alusrcb);
            K_PCSRC:    return 32'(pc_src);
            K_ALUCTL:   return 32'(aluctl);
            K_EXCV:     return 32'(exc_valid);
            K_CAUSE:    return 32'(exc_cause);
            default:    return 32'(retired);
        endcase
    endfunction

    task automatic ex(input kind_e k, input logic [31:0] v);
        exp_t e;
        e.tag  = $sformatf("%s@step%0d", k.name(), step);
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic chk();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind);
            compared++;
            assert (obs === e.val) else begin
                mism++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // One clock: drive inputs, check expectations for the current state.
    task automatic cyc(input state_e s, input logic r, input logic st);
        mif.mem_ready = r;
        stall         = st;
        ex(K_STATE, 32'(s));
        chk();
        step++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; mif.mem_ready = 1'b0; stall = 1'b0;
        opcode = OP_LW; funct = 6'd0; alu_zero = 1'b0;
        exp_ret = 4'd0;
        @(negedge clk);

        // reset state
        ex(K_MEMREQ, 0); ex(K_MEMWE, 0); ex(K_PCEN, 0); ex(K_IRW, 0);
        ex(K_EXCV, 0); ex(K_RET, 0); ex(K_ALUSRCB, 0); ex(K_ALUCTL, 0);
        cyc(IDLE, 0, 0);
        rst_n = 1'b1;
        ex(K_MEMREQ, 0); ex(K_REGW, 0);
        cyc(IDLE, 0, 0);

        // lw with waits in FETCH and MEM_RD
        ex(K_MEMREQ, 1); ex(K_IORD, 0); ex(K_ALUSRCB, 1); ex(K_ALUCTL, 2); ex(K_PCEN, 0);
        cyc(FETCH, 0, 0);
        ex(K_IRW, 0);
        cyc(FETCH, 0, 0);
        ex(K_PCEN, 1); ex(K_IRW, 1); ex(K_PCSRC, 0);
        cyc(FETCH, 1, 0);
        ex(K_ALUSRCB, 3); ex(K_ALUCTL, 2); ex(K_MEMREQ, 0);
        cyc(DECODE, 0, 0);
        ex(K_ALUSRCB, 2); ex(K_ALUSRCA, 1);
        cyc(MEMADR, 0, 0);
        ex(K_MEMREQ, 1); ex(K_IORD, 1); ex(K_MEMWE, 0);
        cyc(MEM_RD, 0, 0);
        cyc(MEM_RD, 1, 0);
        ex(K_REGW, 1); ex(K_MEMTOREG, 1); ex(K_REGDST, 0); ex(K_RET, 0); ex(K_MEMREQ, 0);
        cyc(WB_MEM, 0, 0);
        exp_ret = exp_ret + 4'd1;

        // beq taken
        opcode = OP_BEQ; alu_zero = 1'b1;
        ex(K_RET, 32'(exp_ret));
        cyc(FETCH, 1, 0);
        cyc(DECODE, 0, 0);
        ex(K_PCEN, 1); ex(K_PCSRC, 1); ex(K_ALUCTL, 6);
        cyc(BRANCH, 0, 0);
        exp_ret = exp_ret + 4'd1;

        // bne with zero set: not taken
        opcode = OP_BNE;
        ex(K_RET, 32'(exp_ret));
        cyc(FETCH, 1, 0);
        cyc(DECODE, 0, 0);
        ex(K_PCEN, 0); ex(K_PCSRC, 1);
        cyc(BRANCH, 0, 0);
        exp_ret = exp_ret + 4'd1;

        // illegal opcode
        opcode = 6'b111111;
        ex(K_RET, 32'(exp_ret));
        cyc(FETCH, 1, 0);
        ex(K_EXCV, 0);
        cyc(DECODE, 0, 0);
        ex(K_EXCV, 1); ex(K_CAUSE, 1); ex(K_PCSRC, 3); ex(K_PCEN, 1);
        cyc(EXC, 0, 0);

        // jump (also checks the exception did not retire)
        opcode = OP_JUMP;
        ex(K_RET, 32'(exp_ret)); ex(K_EXCV, 0);
        cyc(FETCH, 1, 0);
        cyc(DECODE, 0, 0);
        ex(K_PCSRC, 2); ex(K_PCEN, 1);
        cyc(JUMP, 0, 0);
        exp_ret = exp_ret + 4'd1;

        // subi
        opcode = OP_SUBI;
        ex(K_RET, 32'(exp_ret));
        cyc(FETCH, 1, 0);
        cyc(DECODE, 0, 0);
        ex(K_ALUCTL, 6); ex(K_ALUSRCB, 2); ex(K_REGW, 0);
        cyc(EXEC_I, 0, 0);
        ex(K_REGW, 1); ex(K_REGDST, 0); ex(K_ALUCTL, 6); ex(K_MEMTOREG, 0);
        cyc(WB_I, 0, 0);
        exp_ret = exp_ret + 4'd1;

        // sw with mem_ready held low: timeout after 4 MEM_WR cycles
        opcode = OP_SW;
        ex(K_RET, 32'(exp_ret));
        cyc(FETCH, 1, 0);
        cyc(DECODE, 0, 0);
        cyc(MEMADR, 0, 0);
        ex(K_MEMWE, 1); ex(K_MEMREQ, 1); ex(K_IORD, 1);
        cyc(MEM_WR, 0, 0);
        cyc(MEM_WR, 0, 1);   // stall ignored while a request is live
        cyc(MEM_WR, 0, 0);
        ex(K_EXCV, 0);
        cyc(MEM_WR, 0, 0);
        ex(K_EXCV, 1); ex(K_CAUSE, 2); ex(K_PCSRC, 3); ex(K_MEMREQ, 0);
        cyc(EXC, 0, 0);

        // sw completing on the expiry cycle
        ex(K_RET, 32'(exp_ret));
        cyc(FETCH, 1, 0);
        cyc(DECODE, 0, 0);
        cyc(MEMADR, 0, 0);
        cyc(MEM_WR, 0, 0);
        cyc(MEM_WR, 0, 0);
        cyc(MEM_WR, 0, 0);
        ex(K_EXCV, 0); ex(K_MEMWE, 1);
        cyc(MEM_WR, 1, 0);
        exp_ret = exp_ret + 4'd1;

        // reset in the middle of MEM_WR
        ex(K_RET, 32'(exp_ret)); ex(K_EXCV, 0);
        cyc(FETCH, 1, 0);
        cyc(DECODE, 0, 0);
        cyc(MEMADR, 0, 0);
        ex(K_MEMREQ, 1);
        cyc(MEM_WR, 0, 0);
        rst_n = 1'b0;
        ex(K_STATE, 32'(IDLE)); ex(K_MEMREQ, 0); ex(K_MEMWE, 0); ex(K_RET, 0);
        chk();
        @(negedge clk);
        rst_n = 1'b1;
        exp_ret = 4'd0;
        ex(K_MEMREQ, 0);
        cyc(IDLE, 1, 0);

        // 17 adds with stalls; 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            f = 6'(i * 5 + 3);
            opcode = OP_ADD; funct = f;
            ex(K_RET, 32'(exp_ret));
            cyc(FETCH, 1, 0);
            if (i == 2) cyc(DECODE, 0, 1);
            cyc(DECODE, 0, 0);
            if (i % 4 == 0) begin
                ex(K_REGW, 0); ex(K_ALUCTL, 32'(f[3:0]));
                cyc(EXEC_R, 0, 1);
            end
            ex(K_ALUCTL, 32'(f[3:0])); ex(K_ALUSRCB, 0); ex(K_ALUSRCA, 1); ex(K_REGW, 0);
            cyc(EXEC_R, 0, 0);
            if (i == 5) begin
                ex(K_REGW, 0);
                cyc(WB_R, 0, 1);
            end
            ex(K_REGW, 1); ex(K_REGDST, 1); ex(K_MEMTOREG, 0); ex(K_ALUCTL, 32'(f[3:0]));
            cyc(WB_R, 0, 0);
            exp_ret = exp_ret + 4'd1;
        end
        ex(K_RET, 32'd1);
        cyc(FETCH, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
